gate_fire_scheduler: RTL

GATE_FIRE_SCHEDULER -- requirements
Module: gate_fire_scheduler

---
 rtl/gate_fire_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/gate_fire_scheduler.sv
// gate_fire_scheduler: round-robin firing scheduler for self-timed gates.
// A gate is excited when its current output differs from its pre-capture value.
// Each firing runs IDLE -> PICK -> FIRE -> SETTLE. PICK grants one excited gate,
// starting at a rotating pointer. FIRE drives a one-cycle capture enable.
// SETTLE reports which gate fired.
// Optional feature: define GATE_FIRE_CNT_EN to add the 16-bit o_fire_cnt
// counter of completed firings.
module gate_fire_scheduler #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          i_ck,
  input  logic          i_rs,
  input  logic          i_step,
  input  logic          i_run,
  input  logic [N-1:0]  i_q,
  input  logic [N-1:0]  i_precap,
  output logic [N-1:0]  o_ena,
  output logic          o_busy,
  output logic          o_fired,
  output logic [IW-1:0] o_fired_idx,
  output logic          o_stable
`ifdef GATE_FIRE_CNT_EN
  ,
  output logic [15:0]   o_fire_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PICK   = 2'd1,
    S_FIRE   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_sel;
  logic [N-1:0]  r_ena;
  logic          r_fired;
  logic [IW-1:0] r_fired_idx;
  logic          r_stable;

  logic [IW-1:0] w_ptr_next;
  logic [IW-1:0] w_sel_next;
  logic [N-1:0]  w_ena_next;
  logic          w_fired_next;
  logic [IW-1:0] w_fired_idx_next;
  logic          w_stable_next;

  // The excitation vector is rotated so the pointer position lands at bit 0.
  // The lowest set bit is then the first excited gate in round-robin order.
  logic [N-1:0]   w_exc;
  logic [2*N-1:0] w_rot_full;
  logic [N-1:0]   w_rot;
  logic           w_found;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;
  logic [IW:0]    w_sum_wrap;
  logic [IW-1:0]  w_sel;
  logic [IW-1:0]  w_sel_inc;
  logic [N-1:0]   w_onehot;

  assign w_exc      = i_q ^ i_precap;
  assign w_rot_full = {w_exc, w_exc} >> r_ptr;
  assign w_rot      = w_rot_full[N-1:0];

  // Find the offset of the lowest excited bit after rotation.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IW'(i);
      end
    end
  end

  // Undo the rotation modulo N; N need not be a power of two.
  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sum_wrap = w_sum - (IW+1)'(N);
  assign w_sel      = (w_sum >= (IW+1)'(N)) ? w_sum_wrap[IW-1:0] : w_sum[IW-1:0];
  assign w_sel_inc  = (w_sel == IW'(N - 1)) ? '0 : (w_sel + IW'(1));
  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_sel;

  // Compute the next state and the next values of all registered outputs.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_sel_next       = r_sel;
    w_ena_next       = '0;
    w_fired_next     = 1'b0;
    w_fired_idx_next = r_fired_idx;
    w_stable_next    = r_stable;
    case (r_state)
      S_IDLE: begin
        if (i_step || i_run) begin
          w_state_next = S_PICK;
        end
      end
      S_PICK: begin
        if (w_found) begin
          w_state_next  = S_FIRE;
          w_ena_next    = w_onehot;
          w_sel_next    = w_sel;
          w_ptr_next    = w_sel_inc;
          w_stable_next = 1'b0;
        end else begin
          w_state_next  = S_IDLE;
          w_stable_next = 1'b1;
        end
      end
      S_FIRE: begin
        // The gate captures on this edge; report it during SETTLE.
        w_state_next     = S_SETTLE;
        w_fired_next     = 1'b1;
        w_fired_idx_next = r_sel;
      end
      S_SETTLE: begin
        w_state_next = i_run ? S_PICK : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Register the state; reset takes priority over every other input.
  always_ff @(posedge i_ck) begin
    if (i_rs) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Register the pointer, the selection and the outputs.
  always_ff @(posedge i_ck) begin
    if (i_rs) begin
      r_ptr       <= '0;
      r_sel       <= '0;
      r_ena       <= '0;
      r_fired     <= 1'b0;
      r_fired_idx <= '0;
      r_stable    <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_next;
      r_sel       <= w_sel_next;
      r_ena       <= w_ena_next;
      r_fired     <= w_fired_next;
      r_fired_idx <= w_fired_idx_next;
      r_stable    <= w_stable_next;
    end
  end

`ifdef GATE_FIRE_CNT_EN
  logic [15:0] r_fire_cnt;

  // Count completed firings; the counter advances on the edge that raises FIRED.
  always_ff @(posedge i_ck) begin
    if (i_rs) begin
      r_fire_cnt <= '0;
    end else if (w_fired_next) begin
      r_fire_cnt <= r_fire_cnt + 16'd1;
    end
  end

  assign o_fire_cnt = r_fire_cnt;
`endif

  assign o_ena       = r_ena;
  assign o_busy      = (r_state != S_IDLE);
  assign o_fired     = r_fired;
  assign o_fired_idx = r_fired_idx;
  assign o_stable    = r_stable;

endmodule
